// File: rtl/cruise_input_conditioner.sv
// Cruise control input front end: synchronizes and debounces the raw driver pedals
// and switches, producing clean levels and single-cycle, prioritized command pulses.
module cruise_input_conditioner #(
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 4,
    parameter int CW           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       throttle_raw,
    input  logic       brake_raw,
    input  logic       set_raw,
    input  logic       resume_raw,
    input  logic       accel_raw,
    input  logic       coast_raw,
    input  logic       cancel_raw,
    output logic       throttle,
    output logic       brake,
    output logic       set,
    output logic       resume,
    output logic       accel,
    output logic       coast,
    output logic       cancel,
    output logic [1:0] repeat_state
);
    localparam int N     = 7;
    localparam int I_THR = 0;
    localparam int I_BRK = 1;
    localparam int I_SET = 2;
    localparam int I_RES = 3;
    localparam int I_ACC = 4;
    localparam int I_COA = 5;
    localparam int I_CAN = 6;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_REPEAT = 2'd2
    } rstate_t;

    logic [N-1:0]  raw;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  db;
    logic [CW-1:0] cnt [N];
    logic [N-1:2]  db_q;
    logic [N-1:2]  press;

    assign raw = {cancel_raw, coast_raw, accel_raw, resume_raw,
                  set_raw, brake_raw, throttle_raw};

    // Two-flop synchronizers feeding one stability counter per input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= '0;
            s2   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw;
            s2   <= s1;
            db_q <= db[N-1:2];
            for (int i = 0; i < N; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    db[i]  <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign press    = db[N-1:2] & ~db_q;
    assign throttle = db[I_THR];
    // The raw synchronized level asserts brake without waiting for debounce.
    assign brake    = s2[I_BRK] | db[I_BRK];

    rstate_t       state;
    rstate_t       state_nx;
    logic          key;
    logic          key_nx;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nx;
    logic          acc_req;
    logic          coa_req;
    logic          kill;
    logic          hi_cmd;
    logic          key_held;
    logic          other_rise;

    assign kill       = brake | press[I_CAN];
    assign hi_cmd     = press[I_SET] | press[I_RES];
    assign key_held   = key ? db[I_COA] : db[I_ACC];
    assign other_rise = key ? press[I_ACC] : press[I_COA];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= R_IDLE;
            key   <= 1'b0;
            rcnt  <= '0;
        end else begin
            state <= state_nx;
            key   <= key_nx;
            rcnt  <= rcnt_nx;
        end
    end

    // key: 0 = accel, 1 = coast.
    always_comb begin
        state_nx = state;
        key_nx   = key;
        rcnt_nx  = rcnt;
        acc_req  = 1'b0;
        coa_req  = 1'b0;
        case (state)
            R_IDLE: begin
                if (!kill && !hi_cmd && (press[I_ACC] ^ press[I_COA])) begin
                    acc_req  = press[I_ACC];
                    coa_req  = press[I_COA];
                    key_nx   = press[I_COA];
                    rcnt_nx  = '0;
                    state_nx = R_DELAY;
                end
            end
            R_DELAY: begin
                if (kill || !key_held || other_rise) begin
                    rcnt_nx  = '0;
                    state_nx = R_IDLE;
                end else if (rcnt == CW'(REPEAT_DELAY - 1)) begin
                    acc_req  = ~key;
                    coa_req  = key;
                    rcnt_nx  = '0;
                    state_nx = R_REPEAT;
                end else begin
                    rcnt_nx = rcnt + CW'(1);
                end
            end
            R_REPEAT: begin
                if (kill || !key_held || other_rise) begin
                    rcnt_nx  = '0;
                    state_nx = R_IDLE;
                end else if (rcnt == CW'(REPEAT_RATE - 1)) begin
                    acc_req = ~key;
                    coa_req = key;
                    rcnt_nx = '0;
                end else begin
                    rcnt_nx = rcnt + CW'(1);
                end
            end
            default: begin
                rcnt_nx  = '0;
                state_nx = R_IDLE;
            end
        endcase
    end

    assign repeat_state = state;

    logic set_nx;
    logic resume_nx;
    logic accel_nx;
    logic coast_nx;
    logic cancel_nx;

    // Cancel overrides everything; brake blocks the rest; lower events are dropped.
    always_comb begin
        cancel_nx = press[I_CAN];
        set_nx    = 1'b0;
        resume_nx = 1'b0;
        accel_nx  = 1'b0;
        coast_nx  = 1'b0;
        if (!press[I_CAN] && !brake) begin
            if (press[I_SET]) begin
                set_nx = 1'b1;
            end else if (press[I_RES]) begin
                resume_nx = 1'b1;
            end else begin
                accel_nx = acc_req;
                coast_nx = coa_req;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            set    <= 1'b0;
            resume <= 1'b0;
            accel  <= 1'b0;
            coast  <= 1'b0;
            cancel <= 1'b0;
        end else begin
            set    <= set_nx;
            resume <= resume_nx;
            accel  <= accel_nx;
            coast  <= coast_nx;
            cancel <= cancel_nx;
        end
    end

endmodule

// File: tb/tb_cruise_input_conditioner.sv
// Directed bench for cruise_input_conditioner: each test starts from reset and checks
// the outputs after every clock edge against hand-derived edge numbers.
module tb_cruise_input_conditioner;
    logic       clk = 1'b0;
    logic       reset;
    logic       throttle_raw, brake_raw, set_raw, resume_raw;
    logic       accel_raw, coast_raw, cancel_raw;
    logic       throttle, brake, set, resume, accel, coast, cancel;
    logic [1:0] repeat_state;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    cruise_input_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .throttle_raw (throttle_raw),
        .brake_raw    (brake_raw),
        .set_raw      (set_raw),
        .resume_raw   (resume_raw),
        .accel_raw    (accel_raw),
        .coast_raw    (coast_raw),
        .cancel_raw   (cancel_raw),
        .throttle     (throttle),
        .brake        (brake),
        .set          (set),
        .resume       (resume),
        .accel        (accel),
        .coast        (coast),
        .cancel       (cancel),
        .repeat_state (repeat_state)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic clear_raw();
        throttle_raw = 1'b0;
        brake_raw    = 1'b0;
        set_raw      = 1'b0;
        resume_raw   = 1'b0;
        accel_raw    = 1'b0;
        coast_raw    = 1'b0;
        cancel_raw   = 1'b0;
    endtask

    // Leaves time just after "edge 0"; inputs changed now are seen before edge 1.
    task automatic do_reset(input bit keep_raw);
        if (!keep_raw) clear_raw();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 8'({throttle, brake, set, resume, accel, coast, cancel}), 8'd0);
        chk("rst_state", 8'(repeat_state), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        edge_n = 0;
    endtask

    initial begin
        reset = 1'b1;
        clear_raw();

        // set held 10 cycles, released, then re-pressed
        do_reset(1'b0);
        set_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("set_press", 8'(set), 8'(k == 7 || k == 27));
            if (k == 10) set_raw = 1'b0;
            if (k == 20) set_raw = 1'b1;
        end

        // 3-cycle glitches on set and throttle
        do_reset(1'b0);
        set_raw      = 1'b1;
        throttle_raw = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("glitch_set", 8'(set), 8'd0);
            chk("glitch_thr", 8'(throttle), 8'd0);
            if (k == 3) begin
                set_raw      = 1'b0;
                throttle_raw = 1'b0;
            end
        end

        // throttle level held then released
        do_reset(1'b0);
        throttle_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("thr_level", 8'(throttle), 8'(k >= 6 && k < 16));
            if (k == 10) throttle_raw = 1'b0;
        end

        // single-cycle brake glitch
        do_reset(1'b0);
        brake_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("brk_glitch", 8'(brake), 8'(k == 2));
            if (k == 1) brake_raw = 1'b0;
        end

        // brake held 20 cycles
        do_reset(1'b0);
        brake_raw = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("brk_hold", 8'(brake), 8'(k >= 2 && k < 26));
            if (k == 20) brake_raw = 1'b0;
        end

        // accel held: press, delay, then repeat rate; released before edge 41
        do_reset(1'b0);
        accel_raw = 1'b1;
        pulses    = 0;
        for (int k = 1; k <= 55; k++) begin
            step();
            chk("acc_rep", 8'(accel), 8'(k == 7 || (k >= 15 && k <= 43 && (k - 15) % 4 == 0)));
            chk("acc_coast", 8'(coast), 8'd0);
            if (accel) pulses++;
            if (k == 40) accel_raw = 1'b0;
        end
        chk("acc_count", 8'(pulses), 8'd9);

        // coast alone
        do_reset(1'b0);
        coast_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("coa_rep", 8'(coast), 8'(k == 7 || k == 15 || k == 19));
        end

        // accel and coast pressed together
        do_reset(1'b0);
        accel_raw = 1'b1;
        coast_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("both_keys", 8'({accel, coast}), 8'd0);
        end

        // accel held, coast pressed later aborts repeat
        do_reset(1'b0);
        accel_raw = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            step();
            chk("acc_then_coa_a", 8'(accel), 8'(k == 7 || k == 15));
            chk("acc_then_coa_c", 8'(coast), 8'd0);
            if (k == 9) coast_raw = 1'b1;
        end

        // set and cancel together
        do_reset(1'b0);
        set_raw    = 1'b1;
        cancel_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("setcan_can", 8'(cancel), 8'(k == 7));
            chk("setcan_set", 8'(set), 8'd0);
        end

        // resume alone
        do_reset(1'b0);
        resume_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("res_press", 8'(resume), 8'(k == 7));
        end

        // resume while brake held
        do_reset(1'b0);
        brake_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("res_brk_r", 8'(resume), 8'd0);
            chk("res_brk_b", 8'(brake), 8'(k >= 2));
            if (k == 5) resume_raw = 1'b1;
        end

        // cancel during accel repeat
        do_reset(1'b0);
        accel_raw = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("can_rep_a", 8'(accel), 8'(k == 7 || k == 15));
            chk("can_rep_c", 8'(cancel), 8'(k == 17));
            if (k == 10) cancel_raw = 1'b1;
            if (k == 20) cancel_raw = 1'b0;
        end

        // reset asserted while an accel repeat pulse is high
        do_reset(1'b0);
        accel_raw = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            chk("pre_rst_acc", 8'(accel), 8'(k == 7 || k == 15 || k == 19));
        end
        reset = 1'b1;
        #1;
        chk("async_rst_outs", 8'({throttle, brake, set, resume, accel, coast, cancel}), 8'd0);
        chk("async_rst_state", 8'(repeat_state), 8'd0);
        // accel still held across release: the edge after release is edge 1, bench edge 0
        do_reset(1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("post_rst_acc", 8'(accel), 8'(k == 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
